seven_seg_capture: RTL

Receive-side companion of the multiplexed seven-segment scan bus. Samples the 5-bit digit index and 5-bit digit value driven by the display scanner, deglitches each digit dwell, reassembles the eight 12-bit registers (three nibble slots plus one blank slot per register), and presents them as a flat register bank with per-register update and frame-complete strobes. Used on the observing board (or test harness) to read back what the scanner is displaying.

---
 rtl/seven_seg_capture.sv | 130 +++++++++++++
 1 files changed

// File: rtl/seven_seg_capture.sv
// Receive side of the multiplexed seven-segment scan bus: deglitches scanner dwells and rebuilds the 8x12-bit register bank.
// Optional saturating error counter enabled by defining SEVEN_SEG_CAPTURE_ERRCNT_EN.
module seven_seg_capture #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  digit_in,
  input  logic [4:0]  display_in,
  output logic [95:0] regs_out,
  output logic [7:0]  reg_update,
  output logic        frame_done,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  logic [9:0]  s1, s2, s3;
  logic [7:0]  stab_cnt;
  logic        cap_q;
  logic [9:0]  cap_word;
  logic [11:0] shadow, shadow_nxt;
  logic [2:0]  shadow_idx;
  logic [2:0]  slot_mask, base_mask, mask_nxt;
  logic [7:0]  frame_mask, frame_hit;
  logic        do_commit, do_err;

  logic [2:0] cap_reg;
  logic [1:0] cap_slot;
  logic [4:0] cap_val;
  assign cap_reg  = cap_word[9:7];
  assign cap_slot = cap_word[6:5];
  assign cap_val  = cap_word[4:0];

  // Capture fires on the cycle the counter reaches STAB_MAX, then it saturates until s2 moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      stab_cnt <= '0;
      cap_q    <= 1'b0;
      cap_word <= '0;
    end else begin
      s1       <= {digit_in, display_in};
      s2       <= s1;
      s3       <= s2;
      if (s2 != s3)
        stab_cnt <= 8'd1;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 8'd1;
      cap_q    <= (s2 == s3) && (stab_cnt == STAB_MAX - 8'd1);
      cap_word <= s3;
    end
  end

  // Switching to a new register discards whatever slots were gathered for the old one.
  always_comb begin
    base_mask  = (cap_reg == shadow_idx) ? slot_mask : 3'b000;
    mask_nxt   = base_mask;
    shadow_nxt = shadow;
    do_commit  = 1'b0;
    do_err     = 1'b0;
    if (cap_slot == 2'd3) begin
      mask_nxt = 3'b000;
      if (cap_val == 5'h1f && base_mask == 3'b111)
        do_commit = 1'b1;
      else
        do_err = 1'b1;
    end else if (cap_val[4]) begin
      mask_nxt = 3'b000;
      do_err   = 1'b1;
    end else begin
      case (cap_slot)
        2'd0:    begin shadow_nxt[3:0]  = cap_val[3:0]; mask_nxt[0] = 1'b1; end
        2'd1:    begin shadow_nxt[7:4]  = cap_val[3:0]; mask_nxt[1] = 1'b1; end
        default: begin shadow_nxt[11:8] = cap_val[3:0]; mask_nxt[2] = 1'b1; end
      endcase
    end
  end

  assign frame_hit = frame_mask | (8'd1 << cap_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      shadow_idx <= '0;
      slot_mask  <= '0;
      frame_mask <= '0;
      regs_out   <= '0;
      reg_update <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      reg_update <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (cap_q) begin
        shadow     <= shadow_nxt;
        shadow_idx <= cap_reg;
        slot_mask  <= mask_nxt;
        err        <= do_err;
        if (do_commit) begin
          for (int n = 0; n < 8; n++)
            if (cap_reg == 3'(n)) regs_out[n*12 +: 12] <= shadow;
          reg_update <= 8'd1 << cap_reg;
          if (frame_hit == 8'hff) begin
            frame_done <= 1'b1;
            frame_mask <= '0;
          end else begin
            frame_mask <= frame_hit;
          end
        end
      end
    end
  end

`ifdef SEVEN_SEG_CAPTURE_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (cap_q && do_err && err_count != 8'hff)
      err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'h00;
`endif

endmodule
